// File: rtl/device_info_regs.sv
// Device information register bank: read-only ID window, atomic 2-word uptime
// counter, saturating bad-access counter and a small writable scratch bank.
module device_info_regs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int NUM_ID      = 8,
  parameter logic [NUM_ID*DATA_WIDTH-1:0] ID_VALUES = '0,
  parameter int NUM_SCRATCH = 4,
  parameter logic [31:0] DEAD_VALUE = 32'hdeadbeef
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_req,
  output logic                  reg_ack,
  input  logic                  reg_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [DATA_WIDTH-1:0] reg_rd_data
);

  localparam int unsigned ID_END    = NUM_ID;
  localparam int unsigned LO_ADDR   = NUM_ID;
  localparam int unsigned HI_ADDR   = NUM_ID + 1;
  localparam int unsigned BAD_ADDR  = NUM_ID + 2;
  localparam int unsigned SCR_BASE  = NUM_ID + 3;
  localparam int unsigned SCR_END   = NUM_ID + 3 + NUM_SCRATCH;
  localparam logic [DATA_WIDTH-1:0] DEAD_W = DATA_WIDTH'(DEAD_VALUE);

  if (DATA_WIDTH < 16) begin : g_bad_width
    $error("device_info_regs: DATA_WIDTH must be >= 16");
  end
  if (NUM_SCRATCH < 1) begin : g_bad_scratch
    $error("device_info_regs: NUM_SCRATCH must be >= 1");
  end
  if (longint'(NUM_ID) + 3 + longint'(NUM_SCRATCH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_map
    $error("device_info_regs: address map does not fit in ADDR_WIDTH");
  end

  logic [2*DATA_WIDTH-1:0] uptime;
  logic [DATA_WIDTH-1:0]   hi_shadow;
  logic [DATA_WIDTH-1:0]   bad_cnt;
  logic [DATA_WIDTH-1:0]   scratch [NUM_SCRATCH];
  logic                    req_acked;

  int unsigned             addr_u;
  logic                    is_id, is_lo, is_hi, is_bad_cnt, is_scratch;
  logic                    bad_access;
  logic [DATA_WIDTH-1:0]   rd_next;

  always_comb begin
    addr_u     = 32'(reg_addr);
    is_id      = addr_u < ID_END;
    is_lo      = addr_u == LO_ADDR;
    is_hi      = addr_u == HI_ADDR;
    is_bad_cnt = addr_u == BAD_ADDR;
    is_scratch = (addr_u >= SCR_BASE) && (addr_u < SCR_END);

    rd_next = DEAD_W;
    for (int unsigned i = 0; i < NUM_ID; i++) begin
      if (addr_u == i) rd_next = ID_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
    end
    if (is_lo)      rd_next = uptime[DATA_WIDTH-1:0];
    if (is_hi)      rd_next = hi_shadow;
    if (is_bad_cnt) rd_next = bad_cnt;
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
      if (addr_u == SCR_BASE + i) rd_next = scratch[i];
    end

    bad_access = !(is_id || is_lo || is_hi || is_bad_cnt || is_scratch) ||
                 (!reg_rd_wr_L && (is_id || is_lo || is_hi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_ack     <= 1'b0;
      reg_rd_data <= '0;
      req_acked   <= 1'b0;
      uptime      <= '0;
      hi_shadow   <= '0;
      bad_cnt     <= '0;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      uptime <= uptime + (2*DATA_WIDTH)'(1);
      if (reg_req && !req_acked) begin
        reg_ack   <= 1'b1;
        req_acked <= 1'b1;
        if (reg_rd_wr_L) begin
          reg_rd_data <= rd_next;
          // LO read latches the upper half from the same sample for an atomic pair
          if (is_lo) hi_shadow <= uptime[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
          for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (addr_u == SCR_BASE + i) scratch[i] <= reg_wr_data;
          end
        end
        if (!reg_rd_wr_L && is_bad_cnt) begin
          bad_cnt <= '0;
        end else if (bad_access && (bad_cnt != '1)) begin
          bad_cnt <= bad_cnt + DATA_WIDTH'(1);
        end
      end else if (reg_req) begin
        reg_ack <= 1'b0;
      end else begin
        reg_ack   <= 1'b0;
        req_acked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_device_info_regs.sv
// Directed self-checking bench for device_info_regs: a 32-bit instance and a
// 16-bit instance sharing clock and reset.
module tb_device_info_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req = 1'b0, rd_wr_L = 1'b1, ack;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;

  logic        req16 = 1'b0, rw16 = 1'b1, ack16;
  logic [3:0]  addr16 = '0;
  logic [15:0] wdata16 = '0, rdata16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  device_info_regs #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_ID(2),
    .ID_VALUES({32'h0000_0102, 32'hCAFE_0001}), .NUM_SCRATCH(4)
  ) dut32 (
    .clk(clk), .reset(reset), .reg_req(req), .reg_ack(ack),
    .reg_rd_wr_L(rd_wr_L), .reg_addr(addr), .reg_wr_data(wdata), .reg_rd_data(rdata)
  );

  device_info_regs #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_ID(2),
    .ID_VALUES({16'h0102, 16'h0001}), .NUM_SCRATCH(1)
  ) dut16 (
    .clk(clk), .reset(reset), .reg_req(req16), .reg_ack(ack16),
    .reg_rd_wr_L(rw16), .reg_addr(addr16), .reg_wr_data(wdata16), .reg_rd_data(rdata16)
  );

  // lat = cycles from first sampled req to ack (0 = no ack within budget); extra = ack seen after
  task automatic access32(input logic rd, input logic [5:0] a, input logic [31:0] wd,
                          output logic [31:0] rdv, output int lat, output int extra);
    @(negedge clk);
    req = 1'b1; rd_wr_L = rd; addr = a; wdata = wd;
    lat = 0; extra = 0; rdv = 'x;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin lat = i; rdv = rdata; end
    end
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    if (ack !== 1'b0) extra = 1;
  endtask

  task automatic access16(input logic rd, input logic [3:0] a, input logic [15:0] wd,
                          output logic [15:0] rdv, output int lat);
    @(negedge clk);
    req16 = 1'b1; rw16 = rd; addr16 = a; wdata16 = wd;
    lat = 0; rdv = 'x;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ack16 === 1'b1) begin lat = i; rdv = rdata16; end
    end
    @(negedge clk); req16 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; int lat, extra;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 00000000", rdata); end
    reset = 1'b0;
    // counter is 1 when this request is sampled (one edge after release)
    access32(1'b1, 6'd2, '0, d, lat, extra);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL uptime_after_reset: got %h expected 00000001", d); end
    access32(1'b1, 6'd0, '0, d, lat, extra);
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL id0: got %h expected cafe0001", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL id0_latency: got %0d expected 1", lat); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL id0_ack_width: got extra ack %0d expected 0", extra); end
    access32(1'b1, 6'd1, '0, d, lat, extra);
    checks++; if (d !== 32'h0000_0102) begin errors++; $display("FAIL id1: got %h expected 00000102", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL id1_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_scratch_hold();
    logic [31:0] d; int lat, extra, acks, first;
    @(negedge clk);
    req = 1'b1; rd_wr_L = 1'b0; addr = 6'd5; wdata = 32'hA5A5_5A5A;
    acks = 0; first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin acks++; if (first == 0) first = i; end
    end
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    checks++; if (acks !== 1) begin errors++; $display("FAIL hold_ack_count: got %0d expected 1", acks); end
    checks++; if (first !== 1) begin errors++; $display("FAIL hold_ack_latency: got %0d expected 1", first); end
    checks++; if (rdata !== 32'h0000_0102) begin errors++; $display("FAIL write_keeps_rd_data: got %h expected 00000102", rdata); end
    access32(1'b1, 6'd5, '0, d, lat, extra);
    checks++; if (d !== 32'hA5A5_5A5A) begin errors++; $display("FAIL scratch0_readback: got %h expected a5a55a5a", d); end
    for (int a = 6; a <= 8; a++) begin
      access32(1'b1, 6'(a), '0, d, lat, extra);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL scratch_other_%0d: got %h expected 00000000", a, d); end
    end
  endtask

  task automatic test_uptime_atomic();
    logic [31:0] d; int lat, extra;
    access32(1'b1, 6'd3, '0, d, lat, extra);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL hi_shadow_initial: got %h expected 00000000", d); end
    @(negedge clk);
    force dut32.uptime = 64'h0000_0001_FFFF_FFFD;
    #1 release dut32.uptime;
    // one edge elapses before the LO request is sampled: counter = 1_FFFF_FFFE
    access32(1'b1, 6'd2, '0, d, lat, extra);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL uptime_lo: got %h expected fffffffe", d); end
    access32(1'b1, 6'd3, '0, d, lat, extra);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL uptime_hi_atomic: got %h expected 00000001", d); end
  endtask

  task automatic test_bad_cnt();
    logic [31:0] d; int lat, extra;
    access32(1'b0, 6'd0, 32'h1234_5678, d, lat, extra);
    access32(1'b1, 6'd63, '0, d, lat, extra);
    checks++; if (d !== 32'hdeadbeef) begin errors++; $display("FAIL unmapped_read: got %h expected deadbeef", d); end
    access32(1'b0, 6'd2, 32'h0, d, lat, extra);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bad_write_ack: got latency %0d expected 1", lat); end
    checks++; if (rdata !== 32'hdeadbeef) begin errors++; $display("FAIL bad_write_rd_data: got %h expected deadbeef", rdata); end
    access32(1'b1, 6'd4, '0, d, lat, extra);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL bad_cnt_count: got %h expected 00000003", d); end
    access32(1'b1, 6'd0, '0, d, lat, extra);
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL id_write_ignored: got %h expected cafe0001", d); end
    access32(1'b0, 6'd4, 32'h5555_5555, d, lat, extra);
    access32(1'b1, 6'd4, '0, d, lat, extra);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL bad_cnt_clear: got %h expected 00000000", d); end
    @(negedge clk);
    force dut32.bad_cnt = 32'hFFFF_FFFF;
    #1 release dut32.bad_cnt;
    access32(1'b1, 6'd63, '0, d, lat, extra);
    access32(1'b1, 6'd4, '0, d, lat, extra);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bad_cnt_saturate: got %h expected ffffffff", d); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; int lat, extra, acks, first;
    @(negedge clk);
    req = 1'b1; rd_wr_L = 1'b1; addr = 6'd0;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pre_reset_ack: got %b expected 1", ack); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL async_reset_ack: got %b expected 0", ack); end
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL in_reset_ack: got %b expected 0", ack); end
    end
    @(negedge clk); reset = 1'b0;
    acks = 0; first = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin acks++; if (first == 0) begin first = i; d = rdata; end end
    end
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    checks++; if (acks !== 1 || first !== 1) begin errors++; $display("FAIL post_reset_ack: got %0d acks first at %0d expected 1 at 1", acks, first); end
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL post_reset_data: got %h expected cafe0001", d); end
    access32(1'b1, 6'd5, '0, d, lat, extra);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_scratch: got %h expected 00000000", d); end
    access32(1'b1, 6'd4, '0, d, lat, extra);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_bad_cnt: got %h expected 00000000", d); end
    access32(1'b1, 6'd3, '0, d, lat, extra);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_hi_shadow: got %h expected 00000000", d); end
  endtask

  task automatic test_width16();
    logic [15:0] d; int lat;
    access16(1'b1, 4'd6, '0, d, lat);
    checks++; if (d !== 16'hbeef) begin errors++; $display("FAIL w16_unmapped_u4: got %h expected beef", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL w16_latency: got %0d expected 1", lat); end
    access16(1'b1, 4'd15, '0, d, lat);
    checks++; if (d !== 16'hbeef) begin errors++; $display("FAIL w16_unmapped_15: got %h expected beef", d); end
    access16(1'b1, 4'd4, '0, d, lat);
    checks++; if (d !== 16'd2) begin errors++; $display("FAIL w16_bad_cnt: got %h expected 0002", d); end
    access16(1'b1, 4'd0, '0, d, lat);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL w16_id0: got %h expected 0001", d); end
    access16(1'b0, 4'd5, 16'h1234, d, lat);
    access16(1'b1, 4'd5, '0, d, lat);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL w16_scratch: got %h expected 1234", d); end
    @(negedge clk);
    force dut16.uptime = 32'h0003_FFFE;
    #1 release dut16.uptime;
    access16(1'b1, 4'd2, '0, d, lat);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL w16_uptime_lo: got %h expected ffff", d); end
    access16(1'b1, 4'd3, '0, d, lat);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL w16_uptime_hi: got %h expected 0003", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scratch_hold();
    test_uptime_atomic();
    test_bad_cnt();
    test_mid_reset();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
